// File: rtl/inst_axi_bridge_pkg.sv
// inst_axi_bridge_pkg: AXI constants and AR state encodings shared by the instruction bridge.
package inst_axi_bridge_pkg;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_e;
endpackage

// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: fetch request/addr_ok/data_ok handshake to single-beat AXI4 reads.
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 0,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic              if_req_op,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_data,
  output logic              bus_err,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [ID_W-1:0]   ar_id,
  output logic [7:0]        ar_len,
  output logic [2:0]        ar_size,
  output logic [1:0]        ar_burst,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last
);
  localparam logic [1:0] MAX_C = 2'(MAX_OUTST);
  ar_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_ok_q, bus_err_q, bus_err_d;
  logic              accept, r_hs, beat;
  assign r_ready = rst;
  assign r_hs    = r_valid & r_ready;
  // beats arriving with nothing in flight are dropped and flagged
  assign beat    = r_hs & (cnt_q != 2'd0);
  assign accept  = (state_q == AR_IDLE) & if_req_valid & ~if_req_op & (cnt_q < MAX_C);
  assign inst_addr_ok = accept;
  assign inst_data_ok = data_ok_q;
  assign inst_data    = data_q;
  assign bus_err      = bus_err_q;
  assign ar_addr      = ar_addr_q;
  assign ar_id        = ID_W'(AXI_ID);
  assign ar_len       = 8'd0;
  assign ar_size      = AXI_SIZE_8B;
  assign ar_burst     = AXI_BURST_INCR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= AR_IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == AR_IDLE && accept) state_d = AR_BUSY;
    else if (state_q == AR_BUSY && ar_ready) state_d = AR_IDLE;
  end
  always_comb begin
    ar_valid = (state_q == AR_BUSY);
  end
  always_comb begin
    cnt_d     = (accept & ~beat) ? cnt_q + 2'd1 : (~accept & beat) ? cnt_q - 2'd1 : cnt_q;
    ar_addr_d = accept ? (inst_addr & ~ADDR_W'(7)) : ar_addr_q;
    data_d    = beat ? r_data : data_q;
    bus_err_d = bus_err_q | (if_req_valid & if_req_op)
              | (r_hs & ((r_resp != AXI_RESP_OKAY) | ~r_last | (cnt_q == 2'd0)));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 2'd0;
      ar_addr_q <= '0;
      data_q    <= '0;
      data_ok_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ar_addr_q <= ar_addr_d;
      data_q    <= data_d;
      data_ok_q <= beat;
      bus_err_q <= bus_err_d;
    end
  end
endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed vectors with hand-computed expectations for inst_axi_bridge.
module tb_inst_axi_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0, if_req_op = 1'b0;
  logic [63:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok, bus_err, ar_valid, r_ready;
  logic [63:0] inst_data, ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_ready = 1'b0, r_valid = 1'b0, r_last = 1'b1;
  logic [63:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00;
  int tests = 0, fails = 0;
  inst_axi_bridge dut (
    .clk(clk), .rst(rst), .if_req_valid(if_req_valid), .if_req_op(if_req_op),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_data(inst_data), .bus_err(bus_err), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [63:0] d);
    r_valid = 1'b1;
    r_data  = d;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    r_valid = 1'b0; ar_ready = 1'b0; if_req_valid = 1'b0; if_req_op = 1'b0;
    r_resp = 2'b00; r_last = 1'b1;
    step();
    rst = 1'b1;
  endtask
  initial begin
    step(); step(); #1;
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_ar_addr", ar_addr, 64'd0);
    chk("rst_data_ok", 64'(inst_data_ok), 64'd0);
    chk("rst_data", inst_data, 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_r_ready", 64'(r_ready), 64'd0);
    chk("ar_consts", {ar_id, ar_len, ar_size, ar_burst}, {4'd0, 8'd0, 3'b011, 2'b01});
    step(); rst = 1'b1; #1;
    chk("r_ready_up", 64'(r_ready), 64'd1);
    // single fetch
    step(); if_req_valid = 1'b1; inst_addr = 64'h8000_0004; #1;
    chk("t1_addr_ok_T", 64'(inst_addr_ok), 64'd1);
    step(); if_req_valid = 1'b0; ar_ready = 1'b1; #1;
    chk("t1_ar_valid", 64'(ar_valid), 64'd1);
    chk("t1_ar_addr", ar_addr, 64'h8000_0000);
    chk("t1_addr_ok_T1", 64'(inst_addr_ok), 64'd0);
    step(); ar_ready = 1'b0; beat(64'h1111_2222_3333_4444); #1;
    chk("t1_ar_valid_drop", 64'(ar_valid), 64'd0);
    chk("t1_no_early_ok", 64'(inst_data_ok), 64'd0);
    step(); r_valid = 1'b0; #1;
    chk("t1_data_ok", 64'(inst_data_ok), 64'd1);
    chk("t1_data", inst_data, 64'h1111_2222_3333_4444);
    step(); #1;
    chk("t1_ok_pulse", 64'(inst_data_ok), 64'd0);
    chk("t1_data_hold", inst_data, 64'h1111_2222_3333_4444);
    // AR back-pressure while the fetch address keeps changing
    if_req_valid = 1'b1; inst_addr = 64'h1000_000C; #1;
    chk("t2_addr_ok", 64'(inst_addr_ok), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(); inst_addr = 64'h2000_0000 + 64'(i * 8); #1;
      chk("t2_ar_valid", 64'(ar_valid), 64'd1);
      chk("t2_ar_addr", ar_addr, 64'h1000_0008);
      chk("t2_addr_ok_busy", 64'(inst_addr_ok), 64'd0);
    end
    step(); inst_addr = 64'h3000_0017; ar_ready = 1'b1; #1;
    chk("t2_ar_addr_still", ar_addr, 64'h1000_0008);
    step(); #1;
    chk("t2_idle_accept", 64'(inst_addr_ok), 64'd1);
    step(); if_req_valid = 1'b0; #1;
    chk("t2_second_ar", ar_addr, 64'h3000_0010);
    // outstanding limit with two in flight
    step(); ar_ready = 1'b0; if_req_valid = 1'b1; inst_addr = 64'h4000_0020; #1;
    chk("t3_full_block", 64'(inst_addr_ok), 64'd0);
    beat(64'hAAAA_0000_0000_0001); #1;
    chk("t3_full_block_beat", 64'(inst_addr_ok), 64'd0);
    step(); r_valid = 1'b0; #1;
    chk("t3_d1_ok", 64'(inst_data_ok), 64'd1);
    chk("t3_d1", inst_data, 64'hAAAA_0000_0000_0001);
    chk("t3_third_accept", 64'(inst_addr_ok), 64'd1);
    step(); if_req_valid = 1'b0; ar_ready = 1'b1; beat(64'hBBBB_0000_0000_0002); #1;
    chk("t3_third_ar", ar_addr, 64'h4000_0020);
    // accept and beat in the same cycle with one in flight
    step(); ar_ready = 1'b0; if_req_valid = 1'b1; inst_addr = 64'h5000_0008;
    beat(64'hCCCC_0000_0000_0003); #1;
    chk("t4_d2", inst_data, 64'hBBBB_0000_0000_0002);
    chk("t4_accept", 64'(inst_addr_ok), 64'd1);
    step(); if_req_valid = 1'b0; r_valid = 1'b0; ar_ready = 1'b1; #1;
    chk("t4_d3_ok", 64'(inst_data_ok), 64'd1);
    chk("t4_d3", inst_data, 64'hCCCC_0000_0000_0003);
    step(); ar_ready = 1'b0; beat(64'hDDDD_0000_0000_0004); #1;
    step(); r_valid = 1'b0; #1;
    chk("t4_d4_ok", 64'(inst_data_ok), 64'd1);
    chk("t4_d4", inst_data, 64'hDDDD_0000_0000_0004);
    chk("t4_no_err", 64'(bus_err), 64'd0);
    // count must now be zero: a spurious beat is dropped and flagged
    beat(64'hEEEE_0000_0000_0005);
    step(); r_valid = 1'b0; #1;
    chk("t5_spur_no_ok", 64'(inst_data_ok), 64'd0);
    chk("t5_spur_data_hold", inst_data, 64'hDDDD_0000_0000_0004);
    chk("t5_spur_err", 64'(bus_err), 64'd1);
    // async reset in the middle of an AR handshake
    if_req_valid = 1'b1; inst_addr = 64'h6000_0000;
    step(); if_req_valid = 1'b0; #1;
    chk("t6_busy", 64'(ar_valid), 64'd1);
    #1 rst = 1'b0; #1;
    chk("t6_async_ar_valid", 64'(ar_valid), 64'd0);
    chk("t6_async_err_clr", 64'(bus_err), 64'd0);
    chk("t6_async_r_ready", 64'(r_ready), 64'd0);
    step(); rst = 1'b1; beat(64'h1234_0000_0000_0006);
    step(); r_valid = 1'b0; #1;
    chk("t6_dropped_no_ok", 64'(inst_data_ok), 64'd0);
    chk("t6_dropped_data", inst_data, 64'd0);
    // error response still returns data
    do_reset();
    step(); if_req_valid = 1'b1; inst_addr = 64'h7000_0008; #1;
    chk("t5_resp_accept", 64'(inst_addr_ok), 64'd1);
    step(); if_req_valid = 1'b0; ar_ready = 1'b1;
    step(); ar_ready = 1'b0; beat(64'h5555_6666_7777_8888); r_resp = 2'b10;
    step(); r_valid = 1'b0; r_resp = 2'b00; #1;
    chk("t5_resp_ok", 64'(inst_data_ok), 64'd1);
    chk("t5_resp_data", inst_data, 64'h5555_6666_7777_8888);
    chk("t5_resp_err", 64'(bus_err), 64'd1);
    // missing r_last flags an error but data is still delivered
    do_reset();
    step(); if_req_valid = 1'b1; inst_addr = 64'h0000_0010;
    step(); if_req_valid = 1'b0; ar_ready = 1'b1;
    step(); ar_ready = 1'b0; beat(64'h0F0F_0F0F_0F0F_0F0F); r_last = 1'b0;
    step(); r_valid = 1'b0; r_last = 1'b1; #1;
    chk("t5_nolast_ok", 64'(inst_data_ok), 64'd1);
    chk("t5_nolast_err", 64'(bus_err), 64'd1);
    // write requests are refused
    do_reset();
    step(); if_req_valid = 1'b1; if_req_op = 1'b1; inst_addr = 64'h9000_0000; #1;
    chk("t5_wr_no_ok", 64'(inst_addr_ok), 64'd0);
    step(); #1;
    chk("t5_wr_no_ok2", 64'(inst_addr_ok), 64'd0);
    chk("t5_wr_no_ar", 64'(ar_valid), 64'd0);
    chk("t5_wr_err", 64'(bus_err), 64'd1);
    if_req_valid = 1'b0; if_req_op = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
